// File: rtl/div_mon_pkg.sv
// div_mon_pkg
// Shared definitions for the divided-clock monitor: the monitor state
// encoding and the default measurement constants for the nominal /9 path.
package div_mon_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_EDGE = 3'd1,
        ACQUIRE   = 3'd2,
        LOCKED    = 3'd3,
        FAULT     = 3'd4
    } mon_state_t;

    localparam int DEF_DIV_RATIO  = 9;
    localparam int DEF_HIGH_MIN   = 4;
    localparam int DEF_HIGH_MAX   = 5;
    localparam int DEF_LOCK_COUNT = 4;
    localparam int DEF_TIMEOUT    = 18;
    localparam int DEF_CNT_W      = 5;

endpackage

// File: rtl/div_edge_sync.sv
// div_edge_sync
// Brings an asynchronous divided clock into the clk domain and flags its
// rising edges.
//   clk     in   sampling clock
//   reset   in   asynchronous, active-high reset
//   div_in  in   divided clock, asynchronous to clk
//   div_s   out  synchronized level (two flops deep)
//   rise    out  one-cycle pulse on each synchronized rising edge
module div_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic div_in,
    output logic div_s,
    output logic rise
);

    logic sync_q1;
    logic div_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q1 <= 1'b0;
            div_s   <= 1'b0;
            div_d   <= 1'b0;
        end else begin
            sync_q1 <= div_in;
            div_s   <= sync_q1;
            div_d   <= div_s;
        end
    end

    assign rise = div_s & ~div_d;

endmodule

// File: rtl/div_clk_monitor.sv
// div_clk_monitor
// Built-in self-check for the divide-by-N clock path. Measures the period
// and high time of the divided clock in clk cycles, declares lock after a
// run of good periods and raises sticky period/duty/timeout errors.
//   clk          in   monitor clock (divider source clock)
//   reset        in   asynchronous, active-high reset
//   enable       in   run; low returns to IDLE and clears status
//   clear_err    in   pulse; clears sticky errors and leaves FAULT
//   div_in       in   divided clock under test (asynchronous)
//   locked       out  in LOCKED state
//   fault        out  in FAULT state
//   err_period   out  sticky: bad period while LOCKED
//   err_duty     out  sticky: high count out of range while LOCKED
//   err_timeout  out  sticky: no rising edge for TIMEOUT cycles
//   last_period  out  last measured period
//   last_high    out  last measured high count
//
// state     | meaning
// IDLE      | disabled, counters and status cleared
// WAIT_EDGE | waiting for a first edge to start measuring from
// ACQUIRE   | counting consecutive good periods towards lock
// LOCKED    | lock declared; any bad period is a fault
// FAULT     | error latched; waits for clear_err
module div_clk_monitor
    import div_mon_pkg::*;
#(
    parameter int DIV_RATIO  = DEF_DIV_RATIO,
    parameter int HIGH_MIN   = DEF_HIGH_MIN,
    parameter int HIGH_MAX   = DEF_HIGH_MAX,
    parameter int LOCK_COUNT = DEF_LOCK_COUNT,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear_err,
    input  logic             div_in,
    output logic             locked,
    output logic             fault,
    output logic             err_period,
    output logic             err_duty,
    output logic             err_timeout,
    output logic [CNT_W-1:0] last_period,
    output logic [CNT_W-1:0] last_high
);

    localparam int GW = $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_W-1:0] RATIO_C   = CNT_W'(DIV_RATIO);
    localparam logic [CNT_W-1:0] HI_MIN_C  = CNT_W'(HIGH_MIN);
    localparam logic [CNT_W-1:0] HI_MAX_C  = CNT_W'(HIGH_MAX);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [GW-1:0]    LOCK_LAST = GW'(LOCK_COUNT - 1);

    logic div_s;
    logic rise;

    mon_state_t       state, state_nx;
    logic [CNT_W-1:0] per_cnt;
    logic [CNT_W-1:0] hi_cnt;
    logic [GW-1:0]    good_cnt, good_nx;
    logic             err_period_nx, err_duty_nx, err_timeout_nx;
    logic             restart_cnt;
    logic             timeout_hit;
    logic             per_ok, hi_ok, period_good;
    logic             measure;

    div_edge_sync u_sync (
        .clk    (clk),
        .reset  (reset),
        .div_in (div_in),
        .div_s  (div_s),
        .rise   (rise)
    );

    // A coincident edge wins over the timeout.
    assign timeout_hit = (per_cnt == TIMEOUT_C) && !rise;
    assign per_ok      = (per_cnt == RATIO_C);
    assign hi_ok       = (hi_cnt >= HI_MIN_C) && (hi_cnt <= HI_MAX_C);
    assign period_good = per_ok && hi_ok;
    assign measure     = rise && ((state == ACQUIRE) || (state == LOCKED));

    always_comb begin
        state_nx       = state;
        good_nx        = good_cnt;
        err_period_nx  = err_period;
        err_duty_nx    = err_duty;
        err_timeout_nx = err_timeout;
        restart_cnt    = 1'b0;

        if (!enable) begin
            state_nx       = IDLE;
            good_nx        = '0;
            err_period_nx  = 1'b0;
            err_duty_nx    = 1'b0;
            err_timeout_nx = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state_nx = WAIT_EDGE;
                    good_nx  = '0;
                end
                WAIT_EDGE: begin
                    if (rise) begin
                        state_nx = ACQUIRE;
                        good_nx  = '0;
                    end else if (timeout_hit) begin
                        state_nx       = FAULT;
                        err_timeout_nx = 1'b1;
                    end
                end
                ACQUIRE: begin
                    if (rise) begin
                        if (period_good) begin
                            good_nx = good_cnt + GW'(1);
                            if (good_cnt == LOCK_LAST) begin
                                state_nx = LOCKED;
                            end
                        end else begin
                            good_nx = '0;
                        end
                    end else if (timeout_hit) begin
                        state_nx       = FAULT;
                        err_timeout_nx = 1'b1;
                    end
                end
                LOCKED: begin
                    if (rise) begin
                        if (!period_good) begin
                            state_nx = FAULT;
                            if (!per_ok) err_period_nx = 1'b1;
                            if (!hi_ok)  err_duty_nx   = 1'b1;
                        end
                    end else if (timeout_hit) begin
                        state_nx       = FAULT;
                        err_timeout_nx = 1'b1;
                    end
                end
                FAULT: begin
                    // Counters keep running here, so a dead input that was
                    // flagged for another reason still earns err_timeout.
                    // An already-set err_timeout is not a new error, which
                    // lets clear_err leave FAULT with the input stuck.
                    if (clear_err) begin
                        err_period_nx = 1'b0;
                        err_duty_nx   = 1'b0;
                        if (timeout_hit && !err_timeout) begin
                            err_timeout_nx = 1'b1;
                        end else begin
                            err_timeout_nx = 1'b0;
                            state_nx       = WAIT_EDGE;
                            good_nx        = '0;
                            restart_cnt    = 1'b1;
                        end
                    end else if (timeout_hit && !err_timeout) begin
                        err_timeout_nx = 1'b1;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    good_nx  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            locked      <= 1'b0;
            fault       <= 1'b0;
            per_cnt     <= '0;
            hi_cnt      <= '0;
            good_cnt    <= '0;
            err_period  <= 1'b0;
            err_duty    <= 1'b0;
            err_timeout <= 1'b0;
            last_period <= '0;
            last_high   <= '0;
        end else begin
            state       <= state_nx;
            locked      <= (state_nx == LOCKED);
            fault       <= (state_nx == FAULT);
            good_cnt    <= good_nx;
            err_period  <= err_period_nx;
            err_duty    <= err_duty_nx;
            err_timeout <= err_timeout_nx;

            // Leaving FAULT re-arms the timeout window from zero so that
            // WAIT_EDGE does not inherit a saturated count.
            if (!enable || (state == IDLE) || restart_cnt) begin
                per_cnt <= '0;
                hi_cnt  <= '0;
            end else if (rise) begin
                per_cnt <= CNT_W'(1);
                hi_cnt  <= CNT_W'(1);
            end else begin
                if (per_cnt != TIMEOUT_C) per_cnt <= per_cnt + CNT_W'(1);
                if (div_s && (hi_cnt != TIMEOUT_C)) hi_cnt <= hi_cnt + CNT_W'(1);
            end

            if (!enable) begin
                last_period <= '0;
                last_high   <= '0;
            end else if (measure) begin
                last_period <= per_cnt;
                last_high   <= hi_cnt;
            end
        end
    end

endmodule

// File: tb/tb_div_clk_monitor.sv
module tb_div_clk_monitor;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       clear_err;
    logic       div_in;
    logic       locked;
    logic       fault;
    logic       err_period;
    logic       err_duty;
    logic       err_timeout;
    logic [4:0] last_period;
    logic [4:0] last_high;

    int n_vec = 0;
    int n_bad = 0;

    div_clk_monitor dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .clear_err   (clear_err),
        .div_in      (div_in),
        .locked      (locked),
        .fault       (fault),
        .err_period  (err_period),
        .err_duty    (err_duty),
        .err_timeout (err_timeout),
        .last_period (last_period),
        .last_high   (last_high)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {locked, fault, err_period, err_duty, err_timeout, last_period, last_high}
    function automatic logic [14:0] mk(input bit l, input bit f, input bit p,
                                       input bit d, input bit t,
                                       input int lp, input int lh);
        logic [4:0] a;
        logic [4:0] b;
        a = lp[4:0];
        b = lh[4:0];
        return {l, f, p, d, t, a, b};
    endfunction

    task automatic chk(input string name, input logic [14:0] exp);
        logic [14:0] act;
        act = {locked, fault, err_period, err_duty, err_timeout, last_period, last_high};
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got l=%0b f=%0b ep=%0b ed=%0b et=%0b per=%0d hi=%0d, want l=%0b f=%0b ep=%0b ed=%0b et=%0b per=%0d hi=%0d",
                     name, act[14], act[13], act[12], act[11], act[10], act[9:5], act[4:0],
                     exp[14], exp[13], exp[12], exp[11], exp[10], exp[9:5], exp[4:0]);
        end
    endtask

    task automatic drive(input int hi, input int per, input int reps);
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < per; i++) begin
                div_in = (i < hi);
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic restart();
        div_in    = 1'b0;
        enable    = 1'b0;
        clear_err = 1'b0;
        reset     = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset  = 1'b0;
        enable = 1'b1;
        @(posedge clk); #1;
    endtask

    typedef struct {
        bit          restart;
        int          hi;
        int          per;
        int          reps;
        logic [14:0] exp;
    } vec_t;

    vec_t vecs[18];

    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        clear_err = 1'b0;
        div_in    = 1'b0;

        // Each row drives reps periods; the rise at the start of a period
        // reports the length of the period before it.
        vecs[0]  = '{1'b1, 5,  9, 5, mk(1,0,0,0,0, 9,5)};
        vecs[1]  = '{1'b0, 4,  9, 1, mk(1,0,0,0,0, 9,5)};
        vecs[2]  = '{1'b0, 6,  9, 1, mk(1,0,0,0,0, 9,4)};
        vecs[3]  = '{1'b0, 5, 10, 1, mk(0,1,0,1,0, 9,6)};
        vecs[4]  = '{1'b1, 5,  9, 5, mk(1,0,0,0,0, 9,5)};
        vecs[5]  = '{1'b0, 5, 10, 1, mk(1,0,0,0,0, 9,5)};
        vecs[6]  = '{1'b0, 5,  9, 1, mk(0,1,1,0,0,10,5)};
        vecs[7]  = '{1'b1, 5,  9, 5, mk(1,0,0,0,0, 9,5)};
        vecs[8]  = '{1'b0, 2,  9, 1, mk(1,0,0,0,0, 9,5)};
        vecs[9]  = '{1'b0, 5,  9, 1, mk(0,1,0,1,0, 9,2)};
        vecs[10] = '{1'b1, 5,  9, 2, mk(0,0,0,0,0, 9,5)};
        vecs[11] = '{1'b0, 5,  8, 1, mk(0,0,0,0,0, 9,5)};
        vecs[12] = '{1'b0, 5,  9, 1, mk(0,0,0,0,0, 8,5)};
        vecs[13] = '{1'b0, 5,  9, 3, mk(0,0,0,0,0, 9,5)};
        vecs[14] = '{1'b0, 5,  9, 1, mk(1,0,0,0,0, 9,5)};
        vecs[15] = '{1'b1, 5,  9, 5, mk(1,0,0,0,0, 9,5)};
        vecs[16] = '{1'b0, 3, 11, 1, mk(1,0,0,0,0, 9,5)};
        vecs[17] = '{1'b0, 5,  9, 1, mk(0,1,1,1,0,11,3)};

        #12;
        chk("reset_state", mk(0,0,0,0,0,0,0));

        for (int v = 0; v < 18; v++) begin
            if (vecs[v].restart) restart();
            drive(vecs[v].hi, vecs[v].per, vecs[v].reps);
            chk($sformatf("row%0d", v), vecs[v].exp);
        end

        // Timeout 18 cycles after the last rise, clear_err ignored while
        // locked, then clear and relock.
        restart();
        drive(5, 9, 5);
        chk("lock_before_timeout", mk(1,0,0,0,0,9,5));
        div_in = 1'b1;
        for (int k = 1; k <= 21; k++) begin
            @(posedge clk); #1;
            if (k == 5)  div_in = 1'b0;
            if (k == 10) clear_err = 1'b1;
            if (k == 11) begin
                clear_err = 1'b0;
                chk("clr_ignored", mk(1,0,0,0,0,9,5));
            end
            if (k == 20) chk("timeout_minus1", mk(1,0,0,0,0,9,5));
            if (k == 21) chk("timeout", mk(0,1,0,0,1,9,5));
        end
        clear_err = 1'b1;
        @(posedge clk); #1;
        clear_err = 1'b0;
        chk("clear_to_wait", mk(0,0,0,0,0,9,5));
        drive(5, 9, 4);
        chk("relock_4", mk(0,0,0,0,0,9,5));
        drive(5, 9, 1);
        chk("relock_5", mk(1,0,0,0,0,9,5));

        // Asynchronous reset mid-period, between clock edges.
        div_in = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2;
        chk("pre_async", mk(1,0,0,0,0,9,5));
        reset = 1'b1;
        #1;
        chk("async_reset", mk(0,0,0,0,0,0,0));
        div_in = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;

        // New timeout coinciding with clear_err in FAULT: the error wins.
        restart();
        drive(5, 9, 5);
        drive(5, 10, 1);
        div_in = 1'b1;
        for (int k = 1; k <= 21; k++) begin
            @(posedge clk); #1;
            if (k == 5) div_in = 1'b0;
            if (k == 20) begin
                chk("pre_err_wins", mk(0,1,1,0,0,10,5));
                clear_err = 1'b1;
            end
            if (k == 21) begin
                clear_err = 1'b0;
                chk("err_wins", mk(0,1,0,0,1,10,5));
            end
        end

        // enable low beats clear_err in FAULT.
        enable    = 1'b0;
        clear_err = 1'b1;
        @(posedge clk); #1;
        clear_err = 1'b0;
        chk("enable_beats_clear", mk(0,0,0,0,0,0,0));
        enable = 1'b1;
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
